ob_cn_sched: RTL

- Scheduler in front of the conditional-command table and the matching engine.
- Steers each ingress command by class:
  - normal commands go to the engine issue slot;
  - conditional commands go to table allocation;
  - cancel commands do a table lookup, then either respond locally or forward to the engine.
- Shares the single registered engine issue slot between ingress normal commands, forwarded cancels and matured conditional commands, with bounded-starvation arbitration.

---
 rtl/ob_cn_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ob_cn_sched.sv
// Conditional-command scheduler: steers ingress by class and arbitrates the
// single registered engine issue slot between normal, forwarded-cancel and
// matured commands.

package ob_pkg;
    localparam int unsigned UID_W = 8;
    localparam int unsigned PX_W  = 16;
    localparam int unsigned QTY_W = 8;

    typedef logic [UID_W-1:0] uid_t;

    typedef struct packed {
        uid_t             uid;
        logic [PX_W-1:0]  px;
        logic [QTY_W-1:0] qty;
    } cmd_t;
endpackage

module ob_cn_sched
    import ob_pkg::*;
#(
    parameter int unsigned MTR_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [1:0] in_cls,
    input  cmd_t       in_cmd,
    output logic       in_rdy,
    output logic       cn_cmd_vld,
    output cmd_t       cn_cmd,
    input  logic       cn_full_r,
    output logic       cn_cancel,
    output uid_t       cn_cancel_uid,
    input  logic       cn_cancel_hit_w,
    input  logic       mtr_vld_r,
    input  cmd_t       mtr_cmd,
    output logic       mtr_accept,
    output logic       eng_vld_r,
    output cmd_t       eng_cmd_r,
    input  logic       eng_rdy,
    output logic       rsp_vld_r,
    output uid_t       rsp_uid_r
);

    localparam int unsigned CNT_W = $clog2(MTR_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LKUP = 2'd1,
        FWD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             lat_q, lat_d;
    logic             eng_vld_q, eng_vld_d;
    cmd_t             eng_cmd_q, eng_cmd_d;
    logic             rsp_vld_q, rsp_vld_d;
    uid_t             rsp_uid_q, rsp_uid_d;

    logic is_cond, is_cancel, norm_pend, slot_free, burst_max;
    logic mtr_grant, norm_grant, squash, hit;

    // Class decode; reserved class 3 behaves as NORMAL
    assign is_cond   = (in_cls == 2'd1);
    assign is_cancel = (in_cls == 2'd2);
    assign norm_pend = in_vld & ~is_cond & ~is_cancel;
    assign slot_free = ~eng_vld_q | eng_rdy;
    assign burst_max = (cnt_q == CNT_W'(MTR_BURST));
    assign squash    = mtr_vld_r & (mtr_cmd.uid == lat_q.uid);
    assign hit       = cn_cancel_hit_w | squash;

    assign cn_cmd        = in_cmd;
    assign cn_cancel_uid = lat_q.uid;
    assign eng_vld_r     = eng_vld_q;
    assign eng_cmd_r     = eng_cmd_q;
    assign rsp_vld_r     = rsp_vld_q;
    assign rsp_uid_r     = rsp_uid_q;

    // Next-state, slot arbitration and same-cycle handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        eng_vld_d  = eng_vld_q & ~eng_rdy;
        eng_cmd_d  = eng_cmd_q;
        rsp_vld_d  = 1'b0;
        rsp_uid_d  = rsp_uid_q;
        in_rdy     = 1'b0;
        cn_cmd_vld = 1'b0;
        cn_cancel  = 1'b0;
        mtr_accept = 1'b0;
        mtr_grant  = 1'b0;
        norm_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_cond) begin
                    in_rdy     = ~cn_full_r;
                    cn_cmd_vld = in_vld & ~cn_full_r;
                end else if (is_cancel) begin
                    in_rdy = 1'b1;
                    if (in_vld) begin
                        lat_d   = in_cmd;
                        state_d = LKUP;
                    end
                end
                // Matured wins unless a waiting normal has been starved MTR_BURST times
                if (slot_free) begin
                    if (mtr_vld_r && !(norm_pend && burst_max)) begin
                        mtr_grant = 1'b1;
                    end else if (norm_pend) begin
                        norm_grant = 1'b1;
                    end
                end
                if (mtr_grant) begin
                    mtr_accept = 1'b1;
                    eng_vld_d  = 1'b1;
                    eng_cmd_d  = mtr_cmd;
                end else if (norm_grant) begin
                    in_rdy    = 1'b1;
                    eng_vld_d = 1'b1;
                    eng_cmd_d = in_cmd;
                end
            end
            LKUP: begin
                cn_cancel  = 1'b1;
                mtr_accept = squash;
                if (hit) begin
                    rsp_vld_d = 1'b1;
                    rsp_uid_d = lat_q.uid;
                    state_d   = IDLE;
                end else begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (slot_free) begin
                    eng_vld_d = 1'b1;
                    eng_cmd_d = lat_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation counter: counts matured grants only while a normal waits
        if (!norm_pend || norm_grant) begin
            cnt_d = '0;
        end else if (mtr_grant && !burst_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            eng_vld_q <= 1'b0;
            eng_cmd_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_uid_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            eng_vld_q <= eng_vld_d;
            eng_cmd_q <= eng_cmd_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_uid_q <= rsp_uid_d;
        end
    end

endmodule
